// File: rtl/rv32i_pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: per-stage enables and
// flushes, data-memory wait watchdog and saturating performance counters.
module rv32i_pipeline_ctrl #(
  parameter int DMEM_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             muldiv_start,
  input  logic             muldiv_done,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             bus_err,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MD_BUSY   = 2'd1,
    ST_DMEM_WAIT = 2'd2,
    ST_HALT      = 2'd3
  } state_e;

  localparam logic [7:0]       TIMEOUT_M1 = 8'(DMEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             run_eval_s, dmem_chk_s, branch_flush_s;

  // Next state, watchdog and same-cycle stage enables/flushes
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    bus_err_d      = bus_err_q;
    run_eval_s     = 1'b0;
    dmem_chk_s     = 1'b0;
    branch_flush_s = 1'b0;
    pc_en          = 1'b0;
    if_id_en       = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_en       = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_en      = 1'b0;
    ex_mem_flush   = 1'b0;
    mem_wb_en      = 1'b0;

    case (state_q)
      ST_RUN: begin
        run_eval_s = 1'b1;
        dmem_chk_s = 1'b1;
      end
      ST_MD_BUSY: begin
        if (muldiv_done) begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          state_d   = ST_RUN;
        end else begin
          ex_mem_en    = 1'b1;
          ex_mem_flush = 1'b1;
          mem_wb_en    = 1'b1;
        end
      end
      ST_DMEM_WAIT: begin
        // The wait counter already holds the count including this cycle's
        // predecessor; timeout fires when the next value would reach the limit.
        if (dmem_ready) begin
          run_eval_s = 1'b1;
          state_d    = ST_RUN;
        end else if (wait_q >= TIMEOUT_M1) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (run_eval_s) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (dmem_chk_s && dmem_req && !dmem_ready) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        state_d   = ST_DMEM_WAIT;
        wait_d    = 8'd1;
      end else if (muldiv_start) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
        state_d      = ST_MD_BUSY;
      end else if (branch_taken) begin
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
        branch_flush_s = 1'b1;
      end else if (load_use_stall) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end else begin
      branch_flush_s = 1'b0;
    end

    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_en    = 1'b0;
    end else begin
      branch_flush_s = branch_flush_s;
    end
  end

  // Saturating performance counters; clear wins over increment
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (perf_clr) begin
      stall_d = {CNT_W{1'b0}};
      flush_d = {CNT_W{1'b0}};
    end else begin
      if (!pc_en && (stall_q != CNT_MAX)) begin
        stall_d = stall_q + CNT_ONE;
      end else begin
        stall_d = stall_q;
      end
      if (branch_flush_s && (flush_q != CNT_MAX)) begin
        flush_d = flush_q + CNT_ONE;
      end else begin
        flush_d = flush_q;
      end
    end
  end

  // State, watchdog and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
      stall_q   <= {CNT_W{1'b0}};
      flush_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign bus_err      = bus_err_q;
  assign state_o      = state_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: doc/rv32i_pipeline_ctrl.md
Name: rv32i_pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It takes the combinational load-use stall from the forwarding/hazard unit, plus EX branch resolution, instruction/data memory wait and multi-cycle mul/div handshakes. It drives per-stage register enables and flushes. It also tracks a data-memory wait watchdog and saturating performance counters.

Parameters:
DMEM_TIMEOUT, 64, DMEM_WAIT cycles before bus error (range 2..255)
CNT_W, 32, width of performance counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load_use_stall  input  1  load-use stall request from hazard unit
branch_taken  input  1  EX-stage branch/jump redirect
imem_ready  input  1  instruction fetch data valid this cycle
dmem_req  input  1  MEM-stage instruction accesses data memory
dmem_ready  input  1  data memory completes access this cycle
muldiv_start  input  1  EX holds a mul/div op (single-cycle pulse on entry)
muldiv_done  input  1  mul/div result valid
perf_clr  input  1  synchronous clear of counters
pc_en  output  1  PC update enable
if_id_en  output  1  IF/ID register enable
if_id_flush  output  1  IF/ID loads bubble
id_ex_en  output  1  ID/EX enable
id_ex_flush  output  1  ID/EX loads bubble
ex_mem_en  output  1  EX/MEM enable
ex_mem_flush  output  1  EX/MEM loads bubble
mem_wb_en  output  1  MEM/WB enable
bus_err  output  1  sticky data-memory timeout flag
state_o  output  2  current state (RUN=0, MD_BUSY=1, DMEM_WAIT=2, HALT=3)
stall_cycles  output  CNT_W  cycles with pc_en=0, saturating
flush_count  output  CNT_W  branch flushes issued, saturating

Behaviour:
- Reset (rst_n low, async): state RUN, bus_err 0, counters 0, wait counter 0. All enables and flushes 0 while rst_n is low.
- Enables/flushes are combinational from state and inputs, effective the same cycle. State, watchdog and counters are registered.
- Default in RUN: all en=1, all flush=0.
- RUN evaluation, highest priority first:
  1. dmem_req & !dmem_ready: all en=0. Next state DMEM_WAIT, wait counter=1.
  2. muldiv_start: pc_en, if_id_en, id_ex_en=0; ex_mem_en=1 with ex_mem_flush=1; mem_wb_en=1. Next state MD_BUSY.
  3. branch_taken: pc_en=1, if_id_flush=1, id_ex_flush=1. flush_count+1.
  4. load_use_stall: pc_en=0, if_id_en=0, id_ex_flush=1. Downstream stages run.
  5. !imem_ready: pc_en=0, if_id_flush=1. Downstream stages run.
- Priority masks all lower items. Example: branch together with load_use_stall acts as a branch only.
- MD_BUSY:
  - While !muldiv_done: same outputs as RUN item 2.
  - On muldiv_done: all en=1, no flush, next state RUN.
  - dmem_req, branch_taken and load_use_stall are ignored, because MEM holds bubbles.
- DMEM_WAIT:
  - While !dmem_ready: all en=0, wait counter increments.
  - On dmem_ready: next state RUN. Outputs are the RUN evaluation with item 1 removed, so items 2-5 apply in that cycle.
  - If the wait counter reaches DMEM_TIMEOUT with dmem_ready still 0: bus_err=1, next state HALT.
- HALT: all en=0, flush=0. Only reset exits; bus_err holds.
- Counters:
  - stall_cycles increments on each post-reset cycle with pc_en=0.
  - Both counters saturate at all-ones.
  - perf_clr zeroes both next edge and overrides any increment in the same cycle.

Test Plan:
- load_use_stall=1 for 1 cycle in RUN -> pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1; stall_cycles 0->1.
- branch_taken=1 with load_use_stall=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1; flush_count=1, stall_cycles unchanged.
- muldiv_start pulse, muldiv_done 4 cycles later -> state_o=1 for 4 cycles with ex_mem_flush=1. Release cycle has all en=1. stall_cycles=4.
- dmem_req=1, dmem_ready=0 for 3 cycles then 1 with load_use_stall=1 -> all en=0 for 3 cycles. Release cycle has id_ex_flush=1, pc_en=0, then state RUN.
- DMEM_TIMEOUT=4, dmem_ready held 0 -> bus_err=1 and state_o=3 after 4 wait cycles. Outputs stay frozen until rst_n pulse clears them.
- Preload stall_cycles to all-ones via a long stall with CNT_W=4 -> holds 15. perf_clr asserted with pc_en=0 -> 0 next cycle.
